// File: rtl/fifo_ctrl_if.sv
// Handshake bundle between the FIFO requester, this control stage and the
// output logic / register-file memory.
//   wr_en, rd_en       : per-cycle write/read requests (master -> slave)
//   state, data_count  : registered operation state and occupancy (slave -> master)
//   wr_ptr, rd_ptr     : registered memory addresses (slave -> master)
//   we, re             : combinational memory strobes (slave -> master)
interface fifo_ctrl_if #(
  parameter int unsigned AW = 3,
  parameter int unsigned CW = 4
) ();
  logic          wr_en;
  logic          rd_en;
  logic [2:0]    state;
  logic [CW-1:0] data_count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          we;
  logic          re;

  modport master (
    output wr_en, rd_en,
    input  state, data_count, wr_ptr, rd_ptr, we, re
  );

  modport slave (
    input  wr_en, rd_en,
    output state, data_count, wr_ptr, rd_ptr, we, re
  );
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO control stage: decides each cycle whether the requested write or read
// is legal, registers the resulting operation state and occupancy for the
// output logic, and owns the circular pointers and strobes for the memory.
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, dominant over requests
//   bus    : fifo_ctrl_if slave (wr_en/rd_en in; state, data_count,
//            wr_ptr, rd_ptr, we, re out)
module fifo_ctrl #(
  parameter int unsigned AW    = 3,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 4
) (
  input logic        clk,
  input logic        reset,
  fifo_ctrl_if.slave bus
);

  // Encoding is shared with the output logic; 110/111 are never produced.
  typedef enum logic [2:0] {
    StInit  = 3'b000,
    StWrite = 3'b001,
    StWrErr = 3'b010,
    StNoOp  = 3'b011,
    StRead  = 3'b100,
    StRdErr = 3'b101
  } state_e;

  state_e        state_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;

  logic full;
  logic empty;
  logic wr_req;
  logic rd_req;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  // Simultaneous requests are refused, so only exclusive ones count.
  assign wr_req = bus.wr_en & ~bus.rd_en;
  assign rd_req = bus.rd_en & ~bus.wr_en;

  // Strobes mirror exactly the accepted-operation conditions below.
  assign bus.we = ~reset & wr_req & ~full;
  assign bus.re = ~reset & rd_req & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StInit;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (wr_req) begin
      if (!full) begin
        state_q  <= StWrite;
        count_q  <= count_q + CW'(1);
        wr_ptr_q <= wr_ptr_q + AW'(1);  // natural rollover gives modulo DEPTH
      end else begin
        state_q  <= StWrErr;
      end
    end else if (rd_req) begin
      if (!empty) begin
        state_q  <= StRead;
        count_q  <= count_q - CW'(1);
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end else begin
        state_q  <= StRdErr;
      end
    end else begin
      state_q <= StNoOp;
    end
  end

  assign bus.state      = state_q;
  assign bus.data_count = count_q;
  assign bus.wr_ptr     = wr_ptr_q;
  assign bus.rd_ptr     = rd_ptr_q;

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control stage directly upstream of the FIFO output-logic block.
- Registers the FIFO operation state and data count and feeds both to the output logic each cycle. The output logic uses them to derive full/empty and the wr_ack/wr_err/rd_ack/rd_err handshakes.
- Also owns the circular read/write pointers and the write/read strobes for the 8-entry register-file memory.
- Decides on each clock edge whether the requested operation is legal: write when not full, read when not empty.

Parameters:
- AW, 3, pointer/address width; depth = 2**AW.
- DEPTH, 8, number of entries; must equal 2**AW.
- CW, 4, data_count width; must hold 0..DEPTH inclusive.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write request for this cycle.
- rd_en  input  1  read request for this cycle.
- state  output  3  registered operation state, to the output logic.
- data_count  output  CW  registered occupancy, to the output logic.
- wr_ptr  output  AW  registered write address, to the memory.
- rd_ptr  output  AW  registered read address, to the memory.
- we  output  1  combinational memory write strobe.
- re  output  1  combinational memory read strobe.

Behaviour:
- State encoding is fixed and shared with the output logic:
  - INIT=000
  - WRITE=001
  - WR_ERR=010
  - NO_OP=011
  - READ=100
  - RD_ERR=101
  - 110 and 111 are never produced.
- Reset, sampled at the rising edge and dominant over all requests:
  - state=INIT, data_count=0, wr_ptr=0, rd_ptr=0.
  - A request in the same cycle is ignored, and no memory write occurs that cycle.
  - Reset asserted mid-stream discards all contents. Pointers and count return to 0, and the stored data is not cleared.
- Decode, evaluated from the current registered data_count and the inputs; the result is registered at the next edge:
  - wr_en=1, rd_en=0, data_count<DEPTH: next state WRITE, data_count+1, wr_ptr+1.
  - wr_en=1, rd_en=0, data_count==DEPTH: next state WR_ERR; count and pointers held.
  - rd_en=1, wr_en=0, data_count>0: next state READ, data_count-1, rd_ptr+1.
  - rd_en=1, wr_en=0, data_count==0: next state RD_ERR; count and pointers held.
  - wr_en=rd_en (both 0 or both 1): next state NO_OP; count and pointers held. Simultaneous requests are intentionally refused, not executed.
- Transitions are the same from every state, including INIT, WR_ERR and RD_ERR. There is no sticky error state; the next cycle's request alone decides.
- Latency:
  - state and data_count reflect a request one cycle after it is presented.
  - The state and the updated count appear together. For example, the 8th accepted write shows state=WRITE with data_count=8, so the output logic reports full in that same cycle.
- Pointer arithmetic is modulo DEPTH. Increment 7 wraps to 0 with no extra logic beyond the natural AW-bit rollover.
- data_count never exceeds DEPTH and never underflows.
- Strobes:
  - we = ~reset & wr_en & ~rd_en & (data_count!=DEPTH).
  - re = ~reset & rd_en & ~wr_en & (data_count!=0).
  - The memory writes at address wr_ptr on the same edge that wr_ptr increments; read data is taken from address rd_ptr.
- Invariant: wr_ptr - rd_ptr (mod DEPTH) equals data_count mod DEPTH at all times.
- No X is ever driven on any output after the first reset.

Test Plan:
- Reset then idle 3 cycles -> state=000, data_count=0, wr_ptr=rd_ptr=0, we=re=0 throughout.
- 8 consecutive writes from empty -> state=001 each cycle; data_count steps 1..8; wr_ptr 1..7 then wraps to 0; we=1 on all 8 request cycles.
- 9th write at data_count=8 -> state=010, data_count stays 8, wr_ptr stays 0, we=0. A following read -> state=100, data_count=7, rd_ptr=1.
- Read when empty after reset -> state=101, count=0, rd_ptr=0, re=0. Next cycle with no request -> state=011.
- wr_en=rd_en=1 with data_count=3 -> state=011, count=3, pointers unchanged, we=re=0.
- With data_count=5 and wr_ptr=5, assert reset together with wr_en -> next cycle state=000, count=0, both pointers=0, we=0 in the reset cycle.
- Wrap test: 8 writes, 8 reads, then 3 writes -> wr_ptr=3, rd_ptr=0, count=3; the invariant holds every cycle.
